// File: rtl/play_core.sv
// -----------------------------------------------------------------------------
// play_core
// Playback engine: fetches consecutive sample words from SDRAM, beginning at a
// controller-supplied word address, and streams them to the DAC path over a
// valid/ready handshake. Supports pause, stop/abort and optional looping.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   play_start            level: high runs a session, low aborts to IDLE
//   play_start_addr       first word address (sampled when a session starts)
//   play_length           words to play (sampled when a session starts)
//   play_pause            level: holds the sample handshake (SEND only)
//   play_stop             abort to IDLE, highest priority
//   play_done             high while the session has finished (DONE)
//   play_read/play_addr   SDRAM read request and word address
//   play_readdata         SDRAM data, valid with play_sdram_finished
//   play_write            always 0 (read-only client)
//   play_sdram_finished   one-cycle SDRAM completion strobe
//   play_audio_data/valid sample to the DAC path
//   play_audio_ready      DAC accepts when valid & ready
// -----------------------------------------------------------------------------
module play_core #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 32,
    parameter int LOOP_EN = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              play_start,
    input  logic [ADDR_W-1:0] play_start_addr,
    input  logic [ADDR_W-1:0] play_length,
    input  logic              play_pause,
    input  logic              play_stop,
    output logic              play_done,
    output logic              play_read,
    output logic [ADDR_W-1:0] play_addr,
    input  logic [DATA_W-1:0] play_readdata,
    output logic              play_write,
    input  logic              play_sdram_finished,
    output logic [DATA_W-1:0] play_audio_data,
    output logic              play_audio_valid,
    input  logic              play_audio_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic              LOOP_S = (LOOP_EN != 0);
    localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    logic [ADDR_W-1:0] len_q,   len_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W-1:0] cnt_q,   cnt_d;
    logic [DATA_W-1:0] data_buf_q, data_buf_d;

    logic              abort_s;
    logic              launch_s;
    logic              xfer_s;
    logic              last_s;
    logic [ADDR_W-1:0] cnt_plus1_s;

    // Event decode shared by the next-state and datapath processes. Valid is
    // built from state and pause only, so ready never feeds back into valid.
    always_comb begin
        abort_s     = play_stop | ~play_start;
        launch_s    = play_start & ~play_stop;
        xfer_s      = (state_q == S_SEND) & ~play_pause & play_audio_ready;
        cnt_plus1_s = cnt_q + ONE_A;
        last_s      = (cnt_plus1_s == len_q);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            base_q     <= ZERO_A;
            len_q      <= ZERO_A;
            addr_q     <= ZERO_A;
            cnt_q      <= ZERO_A;
            data_buf_q <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            data_buf_q <= data_buf_d;
        end
    end

    // Next-state logic; an abort in FETCH/SEND wins over finished and transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (launch_s) begin
                    state_d = (play_length == ZERO_A) ? S_DONE : S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (abort_s) begin
                    state_d = S_IDLE;
                end else if (play_sdram_finished) begin
                    state_d = S_SEND;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_SEND: begin
                if (abort_s) begin
                    state_d = S_IDLE;
                end else if (xfer_s) begin
                    if (last_s && !LOOP_S) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                if (!play_start) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: session latch, read capture, word counting/wrap.
    always_comb begin
        base_d     = base_q;
        len_d      = len_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        data_buf_d = data_buf_q;
        case (state_q)
            S_IDLE: begin
                if (launch_s) begin
                    base_d = play_start_addr;
                    addr_d = play_start_addr;
                    len_d  = play_length;
                    cnt_d  = ZERO_A;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_FETCH: begin
                // A completion that coincides with an abort is discarded.
                if (!abort_s && play_sdram_finished) begin
                    data_buf_d = play_readdata;
                end else begin
                    data_buf_d = data_buf_q;
                end
            end
            S_SEND: begin
                if (!abort_s && xfer_s) begin
                    if (last_s && LOOP_S) begin
                        addr_d = base_q;
                        cnt_d  = ZERO_A;
                    end else begin
                        // Address wraps naturally modulo 2^ADDR_W.
                        addr_d = addr_q + ONE_A;
                        cnt_d  = cnt_plus1_s;
                    end
                end else begin
                    addr_d = addr_q;
                end
            end
            S_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Outputs decoded from the state register and datapath registers.
    always_comb begin
        play_read        = (state_q == S_FETCH);
        play_done        = (state_q == S_DONE);
        play_audio_valid = (state_q == S_SEND) & ~play_pause;
        play_addr        = addr_q;
        play_audio_data  = data_buf_q;
        play_write       = 1'b0;
    end

endmodule

// File: tb/tb_play_core.sv
module tb_play_core;

    localparam int AW = 23;
    localparam int DW = 32;
    localparam logic [AW-1:0] AMASK = 23'h7FFFFF;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_HAVE  = 2;
    localparam int M_DONE  = 3;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          play_start;
    logic [AW-1:0] play_start_addr;
    logic [AW-1:0] play_length;
    logic          play_pause;
    logic          play_stop;
    logic          play_sdram_finished;
    logic [DW-1:0] play_readdata;
    logic          play_audio_ready;

    logic          d0_done, d0_read, d0_write, d0_valid;
    logic [AW-1:0] d0_addr;
    logic [DW-1:0] d0_data;
    logic          d1_done, d1_read, d1_write, d1_valid;
    logic [AW-1:0] d1_addr;
    logic [DW-1:0] d1_data;

    logic          loop_sel;
    logic          cur_done, cur_read, cur_write, cur_valid;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data;

    always #5 i_clk = ~i_clk;

    play_core #(.ADDR_W(AW), .DATA_W(DW), .LOOP_EN(0)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .play_start(play_start), .play_start_addr(play_start_addr),
        .play_length(play_length), .play_pause(play_pause), .play_stop(play_stop),
        .play_done(d0_done), .play_read(d0_read), .play_addr(d0_addr),
        .play_readdata(play_readdata), .play_write(d0_write),
        .play_sdram_finished(play_sdram_finished),
        .play_audio_data(d0_data), .play_audio_valid(d0_valid),
        .play_audio_ready(play_audio_ready)
    );

    play_core #(.ADDR_W(AW), .DATA_W(DW), .LOOP_EN(1)) u_dut_loop (
        .i_clk(i_clk), .i_rst(i_rst),
        .play_start(play_start), .play_start_addr(play_start_addr),
        .play_length(play_length), .play_pause(play_pause), .play_stop(play_stop),
        .play_done(d1_done), .play_read(d1_read), .play_addr(d1_addr),
        .play_readdata(play_readdata), .play_write(d1_write),
        .play_sdram_finished(play_sdram_finished),
        .play_audio_data(d1_data), .play_audio_valid(d1_valid),
        .play_audio_ready(play_audio_ready)
    );

    assign cur_done  = loop_sel ? d1_done  : d0_done;
    assign cur_read  = loop_sel ? d1_read  : d0_read;
    assign cur_write = loop_sel ? d1_write : d0_write;
    assign cur_valid = loop_sel ? d1_valid : d0_valid;
    assign cur_addr  = loop_sel ? d1_addr  : d0_addr;
    assign cur_data  = loop_sel ? d1_data  : d0_data;

    // Reference model: session phase, word index within the session, and the
    // sample the DAC should currently be offered.
    int            phase;
    logic [AW-1:0] base_m, len_m, sent_m;
    int            tot_sent;
    logic [DW-1:0] sample_m;
    bit            req_pending;
    int            lat_cnt;
    int            fin_mode;     // 0 random latency, 1 never finish, 2 finish now
    int            n_checks;
    int            n_fail;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        logic [DW-1:0] x;
        x = {9'd0, a};
        return x * 32'h9E3779B1 + 32'h0BADF00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input logic st, input logic sp, input logic pz, input logic rd);
        logic [AW-1:0] ea;
        @(posedge i_clk);
        #1;
        play_start       = st;
        play_stop        = sp;
        play_pause       = pz;
        play_audio_ready = rd;
        // SDRAM responder
        if (!cur_read) req_pending = 1'b0;
        play_sdram_finished = 1'b0;
        play_readdata       = $urandom;
        if (cur_read) begin
            if (!req_pending) begin
                req_pending = 1'b1;
                lat_cnt     = $urandom_range(0, 3);
            end
            if (fin_mode == 2 || (fin_mode == 0 && lat_cnt == 0)) begin
                play_sdram_finished = 1'b1;
                play_readdata       = word_of(cur_addr);
                req_pending         = 1'b0;
            end else if (lat_cnt > 0) begin
                lat_cnt--;
            end
        end
        #1;
        ea = (base_m + sent_m) & AMASK;
        chk("read",  32'(cur_read),  32'(phase == M_FETCH));
        chk("done",  32'(cur_done),  32'(phase == M_DONE));
        chk("valid", 32'(cur_valid), 32'(phase == M_HAVE && !pz));
        chk("write", 32'(cur_write), 32'd0);
        if (phase == M_FETCH) chk("addr", 32'(cur_addr), 32'(ea));
        if (phase == M_HAVE)  chk("data", cur_data, sample_m);
        // Advance the model to what the next clock edge produces.
        if ((phase == M_FETCH || phase == M_HAVE) && (sp || !st)) begin
            phase = M_IDLE;
        end else begin
            case (phase)
                M_IDLE: if (st && !sp) begin
                    base_m = play_start_addr;
                    len_m  = play_length;
                    sent_m = '0;
                    phase  = (play_length == '0) ? M_DONE : M_FETCH;
                end
                M_FETCH: if (play_sdram_finished) begin
                    sample_m = word_of(ea);
                    phase    = M_HAVE;
                end
                M_HAVE: if (!pz && rd) begin
                    tot_sent++;
                    sent_m = sent_m + 23'd1;
                    if (sent_m == len_m) begin
                        if (loop_sel) begin
                            sent_m = '0;
                            phase  = M_FETCH;
                        end else begin
                            phase = M_DONE;
                        end
                    end else begin
                        phase = M_FETCH;
                    end
                end
                M_DONE: if (!st) phase = M_IDLE;
                default: phase = M_IDLE;
            endcase
        end
    endtask

    task automatic run_session(input logic [AW-1:0] base, input logic [AW-1:0] len,
                               input int pz_pct, input int rd_pct,
                               input int max_samples, input int stop_cyc);
        int   cyc;
        bit   stopped;
        logic pz, rd;
        play_start_addr = base;
        play_length     = len;
        tot_sent        = 0;
        cyc             = 0;
        stopped         = 1'b0;
        while (phase != M_DONE && tot_sent < max_samples && cyc < 400 && !stopped) begin
            pz = ($urandom_range(0, 99) < pz_pct);
            rd = ($urandom_range(0, 99) < rd_pct);
            if (cyc == stop_cyc) begin
                tick(1'b1, 1'b1, pz, rd);
                stopped = 1'b1;
            end else begin
                tick(1'b1, 1'b0, pz, rd);
            end
            cyc++;
        end
        chk("session_bound", 32'(cyc < 400), 32'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_read"},  32'(cur_read),  32'd0);
        chk({tag, "_done"},  32'(cur_done),  32'd0);
        chk({tag, "_valid"}, 32'(cur_valid), 32'd0);
        chk({tag, "_addr"},  32'(cur_addr),  32'd0);
        chk({tag, "_data"},  cur_data,       32'd0);
    endtask

    initial begin
        int cyc;
        n_checks = 0; n_fail = 0;
        i_rst = 1'b1;
        play_start = 1'b0; play_stop = 1'b0; play_pause = 1'b0;
        play_start_addr = '0; play_length = '0;
        play_sdram_finished = 1'b0; play_readdata = '0; play_audio_ready = 1'b0;
        loop_sel = 1'b0; phase = M_IDLE; base_m = '0; len_m = '0; sent_m = '0;
        tot_sent = 0; sample_m = '0; req_pending = 1'b0; lat_cnt = 0; fin_mode = 0;

        repeat (2) @(posedge i_clk);
        #1;
        loop_sel = 1'b0; #1; check_zero("rst0");
        loop_sel = 1'b1; #1; check_zero("rst1");
        loop_sel = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;

        // Basic three-word playback, always ready.
        run_session(23'h000100, 23'd3, 0, 100, 1000, -1);
        // Zero length: straight to DONE without a read.
        run_session(23'h000200, 23'd0, 0, 100, 1000, -1);
        // Four words with heavy pausing.
        run_session(23'h000300, 23'd4, 50, 100, 1000, -1);

        // Stop in FETCH coinciding with the SDRAM completion strobe.
        play_start_addr = 23'h000400; play_length = 23'd2;
        fin_mode = 1;
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        fin_mode = 2;
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        fin_mode = 0;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Looping across the top of the address space.
        loop_sel = 1'b1;
        run_session(23'h7FFFFE, 23'd3, 0, 100, 7, -1);
        loop_sel = 1'b0;

        // DAC stalls in SEND, then asynchronous reset mid-word.
        play_start_addr = 23'h000500; play_length = 23'd5;
        cyc = 0;
        while (phase != M_HAVE && cyc < 50) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            cyc++;
        end
        chk("reach_send", 32'(phase == M_HAVE), 32'd1);
        repeat (10) tick(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge i_clk);
        #3;
        i_rst = 1'b1;
        #1;
        check_zero("arst");
        phase = M_IDLE; req_pending = 1'b0; sent_m = '0;
        play_start = 1'b0; play_sdram_finished = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized sessions across both looping modes.
        for (int s = 0; s < 30; s++) begin
            logic [AW-1:0] b;
            logic [AW-1:0] l;
            int            ms;
            int            sc;
            loop_sel = 1'($urandom_range(0, 1));
            b  = ($urandom_range(0, 3) == 0) ? (23'h7FFFFC + 23'($urandom_range(0, 3)))
                                              : 23'($urandom);
            l  = 23'($urandom_range(0, 6));
            ms = loop_sel ? (32'(l) * 2 + 1) : 1000;
            sc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            run_session(b, l, $urandom_range(0, 40), $urandom_range(50, 100), ms, sc);
        end
        loop_sel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/play_core.md
Name: play_core

Overview:
- Playback engine; the read-side counterpart of the recording path.
- Fetches consecutive 32-bit sample words from SDRAM, starting at a controller-supplied address, and streams them to the audio DAC path over a valid/ready handshake.
- Sits between the top-level controller, the SDRAM arbiter port and the audio output interface.
- Supports pause, stop and optional looping.

Parameters:
ADDR_W, 23, SDRAM word-address width
DATA_W, 32, sample word width (16-bit L + 16-bit R)
LOOP_EN, 0, 1 = on reaching end, wrap to start address instead of finishing

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
play_start  in  1  level; high = run session, low = abort to IDLE
play_start_addr  in  ADDR_W  first word address, sampled on IDLE->FETCH
play_length  in  ADDR_W  number of words to play, sampled on IDLE->FETCH
play_pause  in  1  level; high = hold playback
play_stop  in  1  pulse/level; abort to IDLE
play_done  out  1  high in DONE state
play_read  out  1  SDRAM read request, held until finished
play_addr  out  ADDR_W  SDRAM address
play_readdata  in  DATA_W  SDRAM read data, valid when finished=1
play_write  out  1  tied 0
play_sdram_finished  in  1  one-cycle SDRAM completion strobe
play_audio_data  out  DATA_W  sample to DAC
play_audio_valid  out  1  sample valid
play_audio_ready  in  1  DAC accepts sample when valid&ready

Behaviour:
- Reset: state=IDLE.
  - All outputs 0: play_addr=0, play_audio_data=0.
  - Internal base=0, len=0, cnt=0.
- Registers: base, len, addr, cnt (words sent), data_buf. All state is registered; outputs are driven from registers or the state decode, with no combinational path from play_audio_ready to play_audio_valid.
- IDLE:
  - play_start=1 and play_stop=0: latch base=addr=play_start_addr, len=play_length, cnt=0.
  - Go to DONE if play_length==0, else FETCH.
- FETCH:
  - play_read=1, play_addr=addr.
  - On play_sdram_finished: data_buf<=play_readdata, go to SEND.
  - play_read drops the cycle after finished (registered state change).
- SEND:
  - play_audio_data=data_buf.
  - play_audio_valid=1 unless play_pause=1; while paused, valid=0 and data_buf is held.
  - Transfer occurs when valid&ready. Then cnt<=cnt+1 and addr<=addr+1 (wraps modulo 2^ADDR_W).
  - If cnt+1==len:
    - LOOP_EN=0 -> DONE.
    - LOOP_EN=1 -> addr<=base, cnt<=0, FETCH.
  - Otherwise -> FETCH.
- Pause:
  - Affects SEND only.
  - FETCH completes its outstanding read regardless of pause, so SDRAM requests are never dropped by a pause.
- DONE:
  - play_done=1; play_read=0; play_audio_valid=0.
  - Stay until play_start=0 -> IDLE.
- Abort (play_stop=1 or play_start=0, in FETCH/SEND) -> IDLE next cycle.
  - play_read and play_audio_valid drop immediately on that next edge.
  - A finished strobe arriving in the abort cycle is ignored.
  - The arbiter tolerates abandoned reads.
  - play_stop has priority over every other event in the same cycle.
- Simultaneous transfer and last word in SEND: the transfer is counted, then termination occurs. No extra sample is emitted.
- Latency:
  - First play_read asserts 1 cycle after start is seen.
  - Valid asserts the cycle after finished.
  - Minimum per-sample cost: FETCH 1 cycle + SDRAM latency + 1 SEND cycle.
- Reset mid-operation returns everything to reset values asynchronously.

Test Plan:
1. start_addr=0x100, length=3, ready always 1, SDRAM finished 2 cycles after read returns D0..D2.
   -> reads at 0x100,0x101,0x102; DAC receives D0,D1,D2 exactly once; play_done=1 after 3rd transfer; start low -> IDLE.
2. length=0, start=1.
   -> no play_read; play_done=1 on the cycle after start is seen.
3. length=4, play_pause=1 asserted during FETCH of word 1.
   -> read completes, then valid stays 0 while paused with data_buf unchanged; release pause -> word 1 delivered; all 4 words delivered in order.
4. play_stop pulsed during FETCH with finished asserted the same cycle.
   -> IDLE next cycle; play_read=0; no valid; no done.
5. LOOP_EN=1, start_addr=0x7FFFFE, length=3.
   -> addresses 0x7FFFFE,0x7FFFFF,0x000000, then back to 0x7FFFFE; play_done never asserts.
6. ready held 0 for 10 cycles in SEND, async i_rst mid-SEND.
   -> valid and data stable while waiting; all outputs 0 immediately on reset; state IDLE.
